// File: rtl/fp_conv_pkg.sv
// Shared types and constants for floating-point format conversion blocks.
package fp_conv_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam logic [4:0] FP16_EXP_INF        = 5'h1F;
  localparam logic [7:0] EXP_BIAS_DIFF       = 8'd112;
  localparam logic [7:0] FP16_SUBN_MIN_EXP32 = 8'd102;
  localparam logic [7:0] FP32_EXP_SPECIAL    = 8'hFF;
  localparam logic [7:0] FP16_NORM_MAX_EXP32 = EXP_BIAS_DIFF + 8'd30;

  // Classified and aligned operand handed from the classify stage to the round stage.
  typedef struct packed {
    logic      sign;
    logic      round_en;
    logic [4:0] exp;
    logic [9:0] man;
    logic      guard;
    logic      sticky;
    fp_flags_t flags;
  } s1_payload_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even increment on a 10-bit mantissa given guard and sticky bits.
module fp_rne_round (
  input  logic [9:0] man_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  output logic [9:0] man_o,
  output logic       carry_o,
  output logic       inexact_o
);

  logic inc;

  assign inc              = guard_i & (sticky_i | man_i[0]);
  assign {carry_o, man_o} = {1'b0, man_i} + {10'd0, inc};
  assign inexact_o        = guard_i | sticky_i;

endmodule

// File: rtl/fp32_to_fp16_pipe.sv
// Two-stage binary32 -> binary16 converter (classify/align, then round/pack) with valid/ready.
// Define FP32_TO_FP16_STICKY_FLAGS_EN to add the accumulated flags register and its clear input.
module fp32_to_fp16_pipe
  import fp_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] fp32_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] fp16_o,
  output logic [3:0]  flags_o
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr_i,
  output logic [3:0]  flags_sticky_o
`endif
);

  logic [7:0]  exp32;
  logic [22:0] man32;
  logic [7:0]  sub_shift;
  logic [9:0]  sub_man;
  logic        sub_guard;
  logic [22:0] sub_rest;
  s1_payload_t cls;

  logic        s1_valid_d, s1_valid_q;
  s1_payload_t s1_d, s1_q;
  logic        s2_valid_d, s2_valid_q;
  logic [15:0] fp16_d, fp16_q;
  fp_flags_t   flags_d, flags_q;

  logic        s1_adv;
  logic [9:0]  rnd_man;
  logic        rnd_carry;
  logic        rnd_inexact;
  logic [4:0]  exp_r;
  logic [15:0] pack_fp16;
  fp_flags_t   pack_flags;

  assign s1_adv     = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s1_adv;

  assign exp32     = fp32_i[30:23];
  assign man32     = fp32_i[22:0];
  assign sub_shift = 8'd126 - exp32;
  assign {sub_man, sub_guard, sub_rest} = 34'({1'b1, man32, 24'd0} >> sub_shift);

  always_comb begin
    // NOTE: every field gets a default first so no path through the if-chain infers a latch.
    cls      = '0;
    cls.sign = fp32_i[31];
    if (exp32 == FP32_EXP_SPECIAL) begin
      cls.exp = FP16_EXP_INF;
      if (man32 != '0) begin
        cls.man           = {1'b1, man32[21:13]};
        cls.flags.invalid = ~man32[22];
      end
    end else if (exp32 > FP16_NORM_MAX_EXP32) begin
      cls.exp            = FP16_EXP_INF;
      cls.flags.overflow = 1'b1;
      cls.flags.inexact  = 1'b1;
    end else if (exp32 > EXP_BIAS_DIFF) begin
      cls.round_en = 1'b1;
      cls.exp      = 5'(exp32 - EXP_BIAS_DIFF);
      cls.man      = man32[22:13];
      cls.guard    = man32[12];
      cls.sticky   = |man32[11:0];
    end else if (exp32 >= FP16_SUBN_MIN_EXP32) begin
      cls.round_en = 1'b1;
      cls.man      = sub_man;
      cls.guard    = sub_guard;
      cls.sticky   = |sub_rest;
    end else begin
      // Too small even to round up to the smallest subnormal; fp32 subnormals land here too.
      cls.flags.underflow = |fp32_i[30:0];
      cls.flags.inexact   = |fp32_i[30:0];
    end
  end

  fp_rne_round u_round (
    .man_i     (s1_q.man),
    .guard_i   (s1_q.guard),
    .sticky_i  (s1_q.sticky),
    .man_o     (rnd_man),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  // A mantissa carry bumps the exponent; from subnormal this yields the minimum normal.
  assign exp_r = s1_q.exp + {4'd0, rnd_carry};

  always_comb begin
    pack_fp16  = {s1_q.sign, s1_q.exp, s1_q.man};
    pack_flags = s1_q.flags;
    if (s1_q.round_en) begin
      pack_flags = '0;
      if (exp_r == FP16_EXP_INF) begin
        pack_fp16           = {s1_q.sign, FP16_EXP_INF, 10'd0};
        pack_flags.overflow = 1'b1;
        pack_flags.inexact  = 1'b1;
      end else begin
        pack_fp16            = {s1_q.sign, exp_r, rnd_man};
        pack_flags.inexact   = rnd_inexact;
        pack_flags.underflow = rnd_inexact & (s1_q.exp == 5'd0);
      end
    end
  end

  always_comb begin
    s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
    s1_d       = (in_ready_o && in_valid_i) ? cls : s1_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    fp16_d     = (s1_adv && s1_valid_q) ? pack_fp16 : fp16_q;
    flags_d    = (s1_adv && s1_valid_q) ? pack_flags : flags_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      fp16_q     <= 16'h0000;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      fp16_q     <= fp16_d;
      flags_q    <= flags_d;
    end
  end

  // NOTE: the S1 payload is only ever read under s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign out_valid_o = s2_valid_q;
  assign fp16_o      = fp16_q;
  assign flags_o     = flags_q;

`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
  logic [3:0] flags_sticky_d, flags_sticky_q;

  // A clear together with a delivery leaves just the delivered beat's flags.
  always_comb begin
    flags_sticky_d = flags_sticky_q;
    if (flags_clr_i) flags_sticky_d = 4'h0;
    if (out_valid_o && out_ready_i) flags_sticky_d = flags_sticky_d | flags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_sticky_q <= 4'h0;
    else     flags_sticky_q <= flags_sticky_d;
  end

  assign flags_sticky_o = flags_sticky_q;
`endif

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// Self-checking bench for fp32_to_fp16_pipe: directed corner cases, backpressure, reset, random stream.
module tb_fp32_to_fp16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] fp32_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] fp16_o;
  logic [3:0]  flags_o;
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
  logic        flags_clr_i;
  logic [3:0]  flags_sticky_o;
  logic [3:0]  sticky_exp;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] stim_q[$];
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  fp32_to_fp16_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fp32_i      (fp32_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .fp16_o      (fp16_o),
    .flags_o     (flags_o)
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    ,
    .flags_clr_i    (flags_clr_i),
    .flags_sticky_o (flags_sticky_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: exact value M*2^E rounded to the binary16 grid with RNE. Returns {fp16, flags}.
  function automatic logic [19:0] ref_conv(input logic [31:0] a);
    logic s;
    int e, u, sh, base;
    longint m, n, rem, half, bits;
    logic [3:0] f;
    s = a[31];
    e = int'(a[30:23]);
    m = longint'(a[22:0]);
    f = 4'h0;
    if (e == 255) begin
      if (m != 0) return {s, 5'h1F, 1'b1, a[21:13], ~a[22], 3'b000};
      return {s, 15'h7C00, 4'h0};
    end
    if (e == 0) begin
      if (m != 0) f = 4'b0011;
      return {s, 15'd0, f};
    end
    u = e - 127;
    m = m + (longint'(1) << 23);
    if (u > 15) return {s, 15'h7C00, 4'b0101};
    sh   = 13 + ((u < -14) ? (-14 - u) : 0);
    base = (u < -14) ? 0 : (u + 14);
    if (sh > 40) sh = 40;
    n    = m >> sh;
    rem  = m - (n << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && n[0])) n = n + 1;
    bits = longint'(base) * 1024 + n;
    if (bits >= 'h7C00) return {s, 15'h7C00, 4'b0101};
    f[0] = (rem != 0);
    f[1] = (u < -14) && (rem != 0);
    return {s, bits[14:0], f};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    logic [7:0]  edge_e[8] = '{8'd0, 8'd255, 8'd101, 8'd102, 8'd112, 8'd113, 8'd142, 8'd143};
    m = 23'($urandom);
    case ($urandom_range(3))
      0:       return $urandom;
      1:       e = 8'(95 + $urandom_range(55));
      2:       e = edge_e[$urandom_range(7)];
      default: begin
        e       = 8'(98 + $urandom_range(48));
        m[12:0] = ($urandom_range(1) == 1) ? 13'h1000 : 13'h0000;
      end
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    flags_clr_i = 1'b0;
    sticky_exp  = 4'h0;
`endif
    @(negedge clk);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_fp16", fp16_o, 16'h0000);
    check("rst_flags", flags_o, 4'h0);
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    check("rst_sticky", flags_sticky_o, 4'h0);
`endif
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready_o, 1);
  endtask

  // Streams stim_q through the DUT and compares every presented result with exp_q.
  task automatic run_stream(input int valid_pct, input int ready_pct, output int cycles);
    int n = stim_q.size();
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0, stalled = 0;
    in_valid_i = 1'b0;
    while (got < n && cyc < 40 * n + 50) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid_i = 1'b0;
      if (!in_valid_i && sent < n && $urandom_range(99) < valid_pct) begin
        in_valid_i = 1'b1;
        fp32_i     = stim_q[sent];
      end
      out_ready_i = ($urandom_range(99) < ready_pct);
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
      flags_clr_i = ($urandom_range(99) < 5);
`endif
      #1;
      if (stalled) check("hold_valid", out_valid_o, 1);
      if (out_valid_o) check("result", {fp16_o, flags_o}, exp_q[got]);
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
      check("sticky", flags_sticky_o, sticky_exp);
      if (flags_clr_i) sticky_exp = 4'h0;
      if (out_valid_o && out_ready_i) sticky_exp = sticky_exp | exp_q[got][3:0];
`endif
      stalled = out_valid_o && !out_ready_i;
      if (out_valid_o && out_ready_i) got++;
      acc = in_valid_i && in_ready_o;
      if (acc) sent++;
    end
    check("stream_done", got, n);
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    flags_clr_i = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      #1;
      check("no_extra_beat", out_valid_o, 0);
      @(negedge clk);
    end
    cycles = cyc;
  endtask

  logic [31:0] dir_op[13] = '{
    32'h3F800000, 32'h3F801000, 32'h477FE000, 32'h477FF000, 32'hC7800000,
    32'h33800000, 32'h33000000, 32'h33000001, 32'h80000001, 32'h7F800001,
    32'h7FC00000, 32'hFF800000, 32'h387FF000};
  logic [19:0] dir_exp[13] = '{
    {16'h3C00, 4'h0}, {16'h3C00, 4'h1}, {16'h7BFF, 4'h0}, {16'h7C00, 4'h5}, {16'hFC00, 4'h5},
    {16'h0001, 4'h0}, {16'h0000, 4'h3}, {16'h0001, 4'h3}, {16'h8000, 4'h3}, {16'h7E00, 4'h8},
    {16'h7E00, 4'h0}, {16'hFC00, 4'h0}, {16'h0400, 4'h3}};
  logic [31:0] ops4[4] = '{32'h3F800000, 32'h40490FDB, 32'hC0400000, 32'h3E800000};

  initial begin
    int cyc;
    int idx;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    fp32_i      = 32'h0;
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    flags_clr_i = 1'b0;
    sticky_exp  = 4'h0;
`endif
    do_reset();

    // Latency: accepted in cycle 0, result visible in cycle 2.
    @(negedge clk);
    in_valid_i  = 1'b1;
    fp32_i      = 32'h3F800000;
    out_ready_i = 1'b1;
    #1;
    check("lat_in_ready", in_ready_o, 1);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    check("lat_cycle1_valid", out_valid_o, 0);
    @(negedge clk);
    #1;
    check("lat_cycle2", {out_valid_o, fp16_o, flags_o}, {1'b1, 16'h3C00, 4'h0});
    @(negedge clk);
    #1;
    check("lat_drained", out_valid_o, 0);

    // Corner-case vectors, streamed back to back at full rate.
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 13; i++) begin
      stim_q.push_back(dir_op[i]);
      exp_q.push_back(dir_exp[i]);
    end
    run_stream(100, 100, cyc);
    check("dir_throughput", cyc, 13 + 2);

    // Four beats with downstream stalled in cycles 2..5.
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid_i = (idx < 4);
      if (idx < 4) fp32_i = ops4[idx];
      out_ready_i = !(c >= 2 && c <= 5);
      #1;
      if (c == 1) check("bp_in_ready_c1", in_ready_o, 1);
      if (c >= 2 && c <= 5) begin
        check("bp_in_ready_low", in_ready_o, 0);
        check("bp_hold", {out_valid_o, fp16_o, flags_o}, {1'b1, ref_conv(ops4[0])});
      end
      if (c >= 6) check("bp_drain", {out_valid_o, fp16_o, flags_o}, {1'b1, ref_conv(ops4[c - 6])});
      if (in_valid_i && in_ready_o) idx++;
    end
    check("bp_accepted", idx, 4);
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    for (int i = 0; i < 4; i++) sticky_exp = sticky_exp | ref_conv(ops4[i])[3:0];
`endif
    #1;
    check("bp_empty", out_valid_o, 0);

    // Random stream with random source and sink gaps.
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] op;
      op = rand_op();
      stim_q.push_back(op);
      exp_q.push_back(ref_conv(op));
    end
    run_stream(70, 60, cyc);

`ifdef FP32_TO_FP16_STICKY_FLAGS_EN
    @(negedge clk);
    flags_clr_i = 1'b1;
    @(negedge clk);
    flags_clr_i = 1'b0;
    #1;
    check("sticky_after_clr", flags_sticky_o, 4'h0);
`endif

    // Reset with two beats in flight: nothing stale may appear afterwards.
    @(negedge clk);
    in_valid_i  = 1'b1;
    fp32_i      = 32'h3F800000;
    out_ready_i = 1'b0;
    @(negedge clk);
    fp32_i = 32'h40000000;
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    check("flight_valid", out_valid_o, 1);
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_stale", out_valid_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
